counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the counter, 2..8.
REQ-002 Parameter W, default 4: counter and length width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1: reset is asynchronous and active-high; it forces all state to reset values immediately.
REQ-005 Port enable  input  1: count qualifier; the counter advances only in cycles where enable=1.
REQ-006 Port req  input  NREQ: level request per requester; must be held until done or abort.
REQ-007 Port len  input  NREQ*W: packed terminal counts; len[i*W +: W] belongs to requester i.
REQ-008 Port gnt  output  NREQ: one-hot grant, registered; all zero when no owner.
REQ-009 Port busy  output  1: high in state COUNT.
REQ-010 Port cnt_q  output  W: shared counter value, registered.
REQ-011 Port done  output  1: one-cycle pulse marking a completed count.
REQ-012 Port done_id  output  clog2(NREQ): index of the requester that completed; valid when done=1.

Function
REQ-013 The FSM shall have three states: IDLE, COUNT and DONE.
REQ-014 In IDLE with req nonzero, the block shall select a winner round-robin, starting at index (last+1) mod NREQ, where last is the most recent granted index.
REQ-015 On the IDLE-to-COUNT edge, the block shall set gnt to the one-hot winner, latch len_l = len of the winner, clear cnt_q to 0, and update last to the winner.
REQ-016 Grant latency shall be one cycle: req sampled at edge k gives gnt high after edge k.
REQ-017 In IDLE with req = 0, the block shall stay in IDLE with gnt=0 and cnt_q held at 0.
REQ-018 In COUNT with enable=1 and cnt_q != len_l, cnt_q shall increment by 1.
REQ-019 In COUNT with enable=1 and cnt_q == len_l, the FSM shall go to DONE and cnt_q shall hold.
REQ-020 In COUNT with enable=0, cnt_q and the state shall hold; there is no timeout.
REQ-021 A grant of length L shall occupy exactly L+1 enabled COUNT cycles.
REQ-022 len_l=0 shall terminate on the first enabled COUNT cycle.
REQ-023 cnt_q never exceeds len_l, so no wrap-around occurs.
REQ-024 Changes to len after the grant shall be ignored.
REQ-025 In DONE for exactly one cycle: done=1, done_id=owner, gnt=0; the next state shall be IDLE.
REQ-026 A new arbitration shall occur no earlier than the IDLE cycle that follows DONE.
REQ-027 Abort: if the owner's req is 0 in COUNT, the next state shall be IDLE with gnt=0 and cnt_q=0, no done pulse, and last keeping the aborted owner.
REQ-028 When abort and terminal count coincide in the same cycle, abort shall take priority.
REQ-029 Requests from non-owners during COUNT or DONE shall be ignored until IDLE.
REQ-030 done shall never be asserted in the same cycle as busy.

Reset
REQ-031 On reset: state=IDLE, gnt=0, busy=0, cnt_q=0, done=0, done_id=0, len_l=0, last=NREQ-1 (so index 0 has first priority).
REQ-032 Reset asserted mid-COUNT shall clear all state asynchronously with no done pulse.
REQ-033 After reset deassertion, arbitration shall resume on the first clock edge.

Verification
REQ-034 After reset, req=4'b0001, len0=3, enable=1: gnt=0001 one cycle later; cnt_q 0,1,2,3; then done=1 with done_id=0; then IDLE.
REQ-035 req=4'b1111 held with all lengths 0: grants cycle through 0,1,2,3,0 with one done each; each grant spans 3 cycles (COUNT, DONE, IDLE).
REQ-036 len2=5 with enable toggling 1,0 repeatedly: cnt_q advances only on enabled cycles; done arrives after 6 enabled COUNT cycles.
REQ-037 req1 drops at cnt_q=2 of len1=9: next cycle IDLE, gnt=0, cnt_q=0, no done; the next winner is searched from index 2.
REQ-038 Reset asserted asynchronously between edges during COUNT with cnt_q=7: outputs go to reset values immediately; after release, index 0 has first priority.
REQ-039 len=15 (max) with enable=1: cnt_q reaches 15 with no wrap, done follows, and cnt_q=0 after the next grant.

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters.
// The owner counts from 0 to its latched length, then gets a one-cycle done pulse.
module counter_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        len,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [W-1:0]             cnt_q,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic [W-1:0]    len_l;
  logic [IW-1:0]   last;
  logic [W-1:0]    len_arr [NREQ];

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   scan;
  logic [NREQ-1:0] win_onehot;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len[i*W +: W];
  end

  // Scan starts one past the last owner and wraps, so the last owner is tried last.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = last;
    scan       = last;
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = (scan == IW'(NREQ - 1)) ? '0 : scan + IW'(1);
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  assign busy = (state == COUNT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      cnt_q   <= '0;
      len_l   <= '0;
      last    <= IW'(NREQ - 1);
      done_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_q <= '0;
          gnt   <= '0;
          if (win_found) begin
            state <= COUNT;
            gnt   <= win_onehot;
            len_l <= len_arr[win_idx];
            last  <= win_idx;
          end
        end
        COUNT: begin
          // A dropped owner request wins over reaching the terminal count.
          if (!req[last]) begin
            state <= IDLE;
            gnt   <= '0;
            cnt_q <= '0;
          end else if (enable) begin
            if (cnt_q == len_l) begin
              state   <= DONE;
              gnt     <= '0;
              done_id <= last;
            end else begin
              cnt_q <= cnt_q + W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt_q <= '0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Vector-table bench for counter_arbiter: each row is one clock of stimulus
// plus the outputs expected right after that edge, checked through a scoreboard.
module tb_counter_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cnt_q;
  logic        done;
  logic [1:0]  done_id;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic        en;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  cnt;
    logic        done;
    logic [1:0]  did;
    string       name;
  } vec_t;

  vec_t table_q[$];
  vec_t exp_q[$];

  counter_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_q   (cnt_q),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] packLen(input logic [3:0] l3, input logic [3:0] l2,
                                          input logic [3:0] l1, input logic [3:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic void add(input string name, input logic [3:0] r, input logic [15:0] l,
                              input logic e, input logic [3:0] g, input logic b,
                              input logic [3:0] c, input logic d, input logic [1:0] id);
    vec_t v;
    v.name = name; v.req = r; v.len = l; v.en = e;
    v.gnt = g; v.busy = b; v.cnt = c; v.done = d; v.did = id;
    table_q.push_back(v);
  endfunction

  task automatic checkOutput();
    vec_t e;
    logic [11:0] act;
    logic [11:0] expv;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: got nothing to compare, required one entry");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    act  = {gnt, busy, cnt_q, done, (e.done ? done_id : 2'b00)};
    expv = {e.gnt, e.busy, e.cnt, e.done, (e.done ? e.did : 2'b00)};
    if (act !== expv)
      $display("[TB] FAIL %s: got gnt=%b busy=%b cnt=%0d done=%b id=%0d, required gnt=%b busy=%b cnt=%0d done=%b id=%0d",
               e.name, gnt, busy, cnt_q, done, done_id, e.gnt, e.busy, e.cnt, e.done, e.did);
    if (act !== expv) fails++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req    = v.req;
    len    = v.len;
    enable = v.en;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    for (int i = 0; i < table_q.size(); i++)
      applyStimulus(table_q[i]);
    table_q.delete();
  endtask

  task automatic checkIdleNow(input string name);
    logic [11:0] act;
    checks++;
    act = {gnt, busy, cnt_q, done, done_id};
    if (act !== 12'd0) begin
      fails++;
      $display("[TB] FAIL %s: got gnt=%b busy=%b cnt=%0d done=%b id=%0d, required all zero",
               name, gnt, busy, cnt_q, done, done_id);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; req = '0; len = '0; enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; req = '0; len = '0; enable = 1'b0;
    #2;
    checkIdleNow("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic grant of requester 0 with length 3
    add("t1_grant", 4'b0001, packLen(0,0,0,3), 1, 4'b0001, 1, 0, 0, 0);
    add("t1_cnt1",  4'b0001, packLen(0,0,0,3), 1, 4'b0001, 1, 1, 0, 0);
    add("t1_cnt2",  4'b0001, packLen(0,0,0,3), 1, 4'b0001, 1, 2, 0, 0);
    add("t1_cnt3",  4'b0001, packLen(0,0,0,3), 1, 4'b0001, 1, 3, 0, 0);
    add("t1_done",  4'b0001, packLen(0,0,0,3), 1, 4'b0000, 0, 3, 1, 0);
    add("t1_idle",  4'b0000, packLen(0,0,0,3), 1, 4'b0000, 0, 0, 0, 0);
    add("t1_stay",  4'b0000, packLen(0,0,0,3), 1, 4'b0000, 0, 0, 0, 0);
    runTable();

    // All requesting with zero lengths: rotation 0,1,2,3,0
    resetDut();
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        logic [3:0] oh;
        oh = 4'b0001 << order[g];
        add("t2_grant", 4'b1111, 16'h0000, 1, oh,      1, 0, 0, 2'(order[g]));
        add("t2_done",  4'b1111, 16'h0000, 1, 4'b0000, 0, 0, 1, 2'(order[g]));
        add("t2_idle",  4'b1111, 16'h0000, 1, 4'b0000, 0, 0, 0, 0);
      end
    end
    runTable();

    // Gated counting, len change after grant ignored, non-owners ignored, then abort
    add("t3_grant", 4'b0100, packLen(0,5,0,0), 1, 4'b0100, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      add("t3_en",   4'b1101, packLen(4,1,0,0), 1, 4'b0100, 1, 4'(i), 0, 0);
      add("t3_hold", 4'b1101, packLen(4,1,0,0), 0, 4'b0100, 1, 4'(i), 0, 0);
    end
    add("t3_done",  4'b1101, packLen(4,1,0,0), 1, 4'b0000, 0, 5, 1, 2);
    add("t3_idle",  4'b1101, packLen(4,1,0,0), 0, 4'b0000, 0, 0, 0, 0);
    add("t3_next",  4'b1101, packLen(4,1,0,0), 0, 4'b1000, 1, 0, 0, 0);
    add("t3_abort", 4'b0000, packLen(4,1,0,0), 0, 4'b0000, 0, 0, 0, 0);
    runTable();

    // Abort at cnt 2, resume search from index 2, abort beats terminal count
    add("t4_grant",  4'b0010, packLen(0,0,9,0), 1, 4'b0010, 1, 0, 0, 0);
    add("t4_cnt1",   4'b0010, packLen(0,0,9,0), 1, 4'b0010, 1, 1, 0, 0);
    add("t4_cnt2",   4'b0010, packLen(0,0,9,0), 1, 4'b0010, 1, 2, 0, 0);
    add("t4_abort",  4'b0000, packLen(0,0,9,0), 1, 4'b0000, 0, 0, 0, 0);
    add("t4_rr",     4'b1111, packLen(0,0,9,0), 1, 4'b0100, 1, 0, 0, 0);
    add("t4_prio",   4'b1011, packLen(0,0,9,0), 1, 4'b0000, 0, 0, 0, 0);
    add("t4_quiet",  4'b0000, packLen(0,0,9,0), 1, 4'b0000, 0, 0, 0, 0);
    runTable();

    // Asynchronous reset mid-count at cnt 7
    add("t5_grant", 4'b0001, packLen(0,0,0,10), 1, 4'b0001, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      add("t5_cnt", 4'b0001, packLen(0,0,0,10), 1, 4'b0001, 1, 4'(i), 0, 0);
    runTable();
    #2;
    reset = 1'b1; req = '0;
    #1;
    checkIdleNow("t5_async_reset");
    @(negedge clk);
    reset = 1'b0;
    add("t5_first",  4'b1111, 16'h0000, 1, 4'b0001, 1, 0, 0, 0);
    add("t5_drop",   4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0);
    runTable();

    // Maximum length 15 reaches 15 without wrap
    add("t6_g0",    4'b0001, packLen(15,0,0,0), 1, 4'b0001, 1, 0, 0, 0);
    add("t6_d0",    4'b0001, packLen(15,0,0,0), 1, 4'b0000, 0, 0, 1, 0);
    add("t6_i0",    4'b1000, packLen(15,0,0,0), 1, 4'b0000, 0, 0, 0, 0);
    add("t6_g3",    4'b1000, packLen(15,0,0,0), 1, 4'b1000, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++)
      add("t6_cnt", 4'b1000, packLen(15,0,0,0), 1, 4'b1000, 1, 4'(i), 0, 0);
    add("t6_done",  4'b1000, packLen(15,0,0,0), 1, 4'b0000, 0, 15, 1, 3);
    add("t6_idle",  4'b0001, packLen(15,0,0,0), 1, 4'b0000, 0, 0, 0, 0);
    add("t6_regnt", 4'b0001, packLen(15,0,0,0), 1, 4'b0001, 1, 0, 0, 0);
    add("t6_end",   4'b0000, packLen(15,0,0,0), 1, 4'b0000, 0, 0, 0, 0);
    runTable();

    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
